multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS core. It sequences the shared datapath (ALU, unified memory port, IR, PC, register file) through FETCH/DECODE/EXEC/MEM/WB, using a variable number of cycles per instruction. It waits on a memory ready handshake. The ALU function code stays in the existing ALU-control decoder; this block only selects between forced add, forced subtract and function-decode through ALUOp.

Parameters:
ST_W, 4, state register width (14 states used).

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
OpCode  in  6  IR[31:26]; stable from the cycle after IRWrite
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load iff Zero
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR from memory data
RegWrite  out  1  register file write
RegDst  out  2  00=rt, 01=rd, 10=$31
MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC
ALUSrcA  out  2  00=PC, 01=rs, 10=shamt
ALUSrcB  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=function decode
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs
ExtOp  out  1  1=sign-extend, 0=zero-extend
LuOp  out  1  immediate <<16 (lui)
instr_done  out  1  one-cycle pulse in the final cycle of each instruction
Trap  out  1  illegal-instruction pulse (see Optional Feature)
state  out  ST_W  current state, for debug

Behaviour:
- Reset: while reset_n=0 at a clk edge, state<=FETCH (0). All write and request outputs (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, Trap) are forced to 0 combinationally while reset_n=0. Mux selects are 0.
- Outputs are combinational from the state register plus the OpCode, Funct, Zero and mem_ready inputs. The only storage is the state register.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, RWB 7, EXEC_I 8, IWB 9, BRANCH 10, JUMP 11, JR 12, TRAP 13.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only in the cycle mem_ready=1, and the FSM then moves to DECODE. Otherwise it holds FETCH with MemRead still high.
- DECODE: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=00 (branch target into ALUOut). Dispatch:
  - lw(23)/sw(2b) -> MEMADR
  - R-type(00) with Funct 08 -> JR
  - other legal R funct (20-27, 00, 02, 03, 2a, 2b) -> EXEC_R
  - addi(08), addiu(09), andi(0c), slti(0a), sltiu(0b), lui(0f) -> EXEC_I
  - beq(04) -> BRANCH
  - j(02)/jal(03) -> JUMP
  - anything else -> illegal handling
- MEMADR: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01, instr_done=1, then -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1. In that cycle instr_done=1, and the FSM moves to FETCH.
- EXEC_R: ALUSrcB=00, ALUOp=10. ALUSrcA=10 for Funct 00/02/03, else 01. Next -> RWB.
- RWB: RegWrite=1, RegDst=01, MemtoReg=00, instr_done=1, then -> FETCH.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=10. ExtOp=0 for andi, else 1. LuOp=1 for lui. Next -> IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00, instr_done=1, then -> FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, then -> FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. For jal also RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4). Next -> FETCH.
- JR: PCWrite=1, PCSource=11, instr_done=1, then -> FETCH.
- mem_ready sampled outside FETCH/MEMRD/MEMWR is ignored. If mem_ready is held high constantly, lw takes 5 cycles, sw/R/I take 4, and beq/j/jal/jr take 3.
- Reset asserted mid-access: the access is abandoned and no register or PC write occurs on that edge.
- Unreachable state codes 14-15 go to FETCH on the next edge with all enables 0.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an illegal opcode/funct in DECODE goes to TRAP. TRAP asserts Trap=1, PCWrite=1 and instr_done=1 for one cycle, then -> FETCH. The datapath loads PC with 32'h8000_0004 when Trap=1.
- Undefined: an illegal instruction goes DECODE -> FETCH with instr_done=1 (executes as a NOP). Trap is tied to 0 and state 13 is never reached.

Test Plan:
- Reset with reset_n=0 for 2 cycles mid-MEMRD -> state=0, all enables 0; first FETCH cycle after release has MemRead=1.
- add (00/20), mem_ready always 1 -> states 0,1,6,7; RWB has RegWrite=1, RegDst=01; instr_done high exactly once per instruction.
- lw (23) with mem_ready low for 3 cycles in MEMRD -> MemRead=1 and IorD=1 held for 4 cycles; MEMWB has MemtoReg=01.
- beq (04) with Zero=1, then again with Zero=0 -> PCWriteCond=1 and PCSource=01 in both; the datapath PC changes only in the Zero=1 case.
- jal (03) -> JUMP cycle has PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10. jr (00/08) -> PCSource=11.
- Opcode 3f: with ILLEGAL_TRAP_EN -> state 13 and Trap pulse for 1 cycle; without it -> returns to FETCH after DECODE and Trap stays 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundles the signals between the multi-cycle MIPS control FSM and the shared
// datapath (ALU, unified memory port, IR, PC, register file).
//
// Ports / members:
//   OpCode, Funct   instruction fields from the IR
//   Zero            ALU zero flag
//   mem_ready       memory completes the current read/write this cycle
//   PCWrite .. LuOp datapath write enables, requests and mux selects
//   instr_done      one-cycle pulse in the final cycle of each instruction
//   Trap            illegal-instruction pulse
//   state           current FSM state, for debug
//
// Modports:
//   master  the control FSM (drives the control outputs)
//   slave   the datapath side (drives the instruction fields and flags)
interface multicycle_ctrl_if #(
  parameter int ST_W = 4
);
  logic [5:0]      OpCode;
  logic [5:0]      Funct;
  logic            Zero;
  logic            mem_ready;

  logic            PCWrite;
  logic            PCWriteCond;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            RegWrite;
  logic [1:0]      RegDst;
  logic [1:0]      MemtoReg;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;
  logic            ExtOp;
  logic            LuOp;
  logic            instr_done;
  logic            Trap;
  logic [ST_W-1:0] state;

  modport master (
    input  OpCode, Funct, Zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuOp,
           instr_done, Trap, state
  );

  modport slave (
    output OpCode, Funct, Zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuOp,
           instr_done, Trap, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main control FSM of the multi-cycle MIPS core. Sequences the shared datapath
// through FETCH / DECODE / EXEC / MEM / WB with a variable number of cycles per
// instruction, stalling on the memory ready handshake. ALU function selection
// beyond add/sub is left to the external ALU-control decoder (ALUOp=10).
//
// Ports:
//   clk      system clock
//   reset_n  synchronous reset, active-low; also gates every enable to 0
//   bus      multicycle_ctrl_if.master (instruction fields in, controls out)
//
// Optional feature (macro ILLEGAL_TRAP_EN):
//   defined   illegal instructions go DECODE -> TRAP, which pulses Trap,
//             PCWrite and instr_done for one cycle
//   undefined illegal instructions finish in DECODE as a NOP; Trap is 0
module multicycle_ctrl #(
  parameter int ST_W = 4
) (
  input logic               clk,
  input logic               reset_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [ST_W-1:0] FETCH  = 'd0;
  localparam logic [ST_W-1:0] DECODE = 'd1;
  localparam logic [ST_W-1:0] MEMADR = 'd2;
  localparam logic [ST_W-1:0] MEMRD  = 'd3;
  localparam logic [ST_W-1:0] MEMWB  = 'd4;
  localparam logic [ST_W-1:0] MEMWR  = 'd5;
  localparam logic [ST_W-1:0] EXEC_R = 'd6;
  localparam logic [ST_W-1:0] RWB    = 'd7;
  localparam logic [ST_W-1:0] EXEC_I = 'd8;
  localparam logic [ST_W-1:0] IWB    = 'd9;
  localparam logic [ST_W-1:0] BRANCH = 'd10;
  localparam logic [ST_W-1:0] JUMP   = 'd11;
  localparam logic [ST_W-1:0] JR     = 'd12;
  localparam logic [ST_W-1:0] TRAP   = 'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [ST_W-1:0] cur_state;
  logic [ST_W-1:0] nxt_state;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       ext_op;
  logic       lu_op;
  logic       done;
  logic       trap;
  logic       r_funct_legal;
  logic       shift_funct;

  // Legal R-type functions other than jr (jr has its own state).
  always_comb begin
    r_funct_legal = 1'b0;
    case (bus.Funct)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      FN_SLL, FN_SRL, FN_SRA, 6'h2a, 6'h2b: r_funct_legal = 1'b1;
      default:                              r_funct_legal = 1'b0;
    endcase
  end

  // Shifts take the shift amount as ALU operand A instead of rs.
  assign shift_funct = (bus.Funct == FN_SLL) || (bus.Funct == FN_SRL) ||
                       (bus.Funct == FN_SRA);

  always_ff @(posedge clk) begin
    if (!reset_n) cur_state <= FETCH;
    else          cur_state <= nxt_state;
  end

  // Next state and all control outputs. Unlisted states (14, 15 and TRAP when
  // the trap feature is compiled out) fall through to the all-zero defaults
  // and return to FETCH. Reset overrides everything at the end so an
  // abandoned access never writes a register or the PC.
  always_comb begin
    nxt_state     = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    ext_op        = 1'b0;
    lu_op         = 1'b0;
    done          = 1'b0;
    trap          = 1'b0;

    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = DECODE;
        end else begin
          nxt_state = FETCH;
        end
      end

      // ALU precomputes the branch target into ALUOut while dispatching.
      DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        case (bus.OpCode)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_RTYPE: begin
            if (bus.Funct == FN_JR) nxt_state = JR;
            else if (r_funct_legal) nxt_state = EXEC_R;
`ifdef ILLEGAL_TRAP_EN
            else nxt_state = TRAP;
`else
            else begin
              nxt_state = FETCH;
              done      = 1'b1;
            end
`endif
          end
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI:
            nxt_state = EXEC_I;
          OP_BEQ:       nxt_state = BRANCH;
          OP_J, OP_JAL: nxt_state = JUMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            nxt_state = TRAP;
`else
            nxt_state = FETCH;
            done      = 1'b1;
`endif
          end
        endcase
      end

      MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        nxt_state = (bus.OpCode == OP_SW) ? MEMWR : MEMRD;
      end

      MEMRD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        nxt_state = bus.mem_ready ? MEMWB : MEMRD;
      end

      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        done       = 1'b1;
      end

      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = bus.mem_ready;
        nxt_state = bus.mem_ready ? FETCH : MEMWR;
      end

      EXEC_R: begin
        alu_src_a = shift_funct ? 2'b10 : 2'b01;
        alu_op    = 2'b10;
        nxt_state = RWB;
      end

      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        done      = 1'b1;
      end

      EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        ext_op    = (bus.OpCode != OP_ANDI);
        lu_op     = (bus.OpCode == OP_LUI);
        nxt_state = IWB;
      end

      IWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end

      BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        done          = 1'b1;
      end

      // jal links the PC, which already holds PC+4 after FETCH.
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        done      = 1'b1;
        if (bus.OpCode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end

      JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
        done      = 1'b1;
      end

`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        done     = 1'b1;
      end
`endif

      default: nxt_state = FETCH;
    endcase

    if (!reset_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      ext_op        = 1'b0;
      lu_op         = 1'b0;
      done          = 1'b0;
      trap          = 1'b0;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCWriteCond = pc_write_cond;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IRWrite     = ir_write;
  assign bus.RegWrite    = reg_write;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.PCSource    = pc_source;
  assign bus.ExtOp       = ext_op;
  assign bus.LuOp        = lu_op;
  assign bus.instr_done  = done;
  assign bus.Trap        = trap;
  assign bus.state       = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Inputs change on the falling edge and
// outputs are compared 1 ns later, well away from the rising edge that moves
// the FSM. Each step compares the state and the full packed control word.
// Honors ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_op;
    logic       lu_op;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_EXEC_I = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  logic  clk;
  logic  reset_n;
  int    errors;
  int    checks;
  ctrl_t exp;
  ctrl_t obs;
  logic  pc_load;

  multicycle_ctrl_if #(.ST_W(4)) bus ();

  multicycle_ctrl #(.ST_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst,
                bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.ExtOp, bus.LuOp, bus.instr_done, bus.Trap};

  // What the datapath would do with the PC this cycle.
  assign pc_load = bus.PCWrite | (bus.PCWriteCond & bus.Zero);

  task automatic apply_stimulus(input logic rst_n, input logic [5:0] op,
                                input logic [5:0] fn, input logic ready,
                                input logic zero);
    @(negedge clk);
    reset_n       = rst_n;
    bus.OpCode    = op;
    bus.Funct     = fn;
    bus.mem_ready = ready;
    bus.Zero      = zero;
    #1;
  endtask

  task automatic check_bit(input string tag, input logic observed,
                           input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] exp_state);
    checks++;
    assert (bus.state === exp_state)
    else begin
      errors++;
      $error("[TB] FAIL %s.state observed=%0d expected=%0d", tag, bus.state, exp_state);
    end
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s.ctrl observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t fetch_exp(input logic ready);
    fetch_exp           = '0;
    fetch_exp.mem_read  = 1'b1;
    fetch_exp.alu_src_b = 2'b01;
    fetch_exp.ir_write  = ready;
    fetch_exp.pc_write  = ready;
  endfunction

  function automatic ctrl_t decode_exp(input logic nop_done);
    decode_exp            = '0;
    decode_exp.alu_src_b  = 2'b11;
    decode_exp.ext_op     = 1'b1;
    decode_exp.instr_done = nop_done;
  endfunction

  task automatic fetch_decode(input string tag, input logic [5:0] op,
                              input logic [5:0] fn);
    apply_stimulus(1'b1, op, fn, 1'b1, 1'b0);
    exp = fetch_exp(1'b1);
    check_output({tag, ".fetch"}, S_FETCH);
    apply_stimulus(1'b1, op, fn, 1'b1, 1'b0);
    exp = decode_exp(1'b0);
    check_output({tag, ".decode"}, S_DECODE);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    bus.OpCode    = 6'h00;
    bus.Funct     = 6'h00;
    bus.mem_ready = 1'b0;
    bus.Zero      = 1'b0;

    // Power-up reset, two cycles.
    apply_stimulus(1'b0, 6'h00, 6'h20, 1'b1, 1'b0);
    exp = '0;
    check_output("reset0", S_FETCH);
    apply_stimulus(1'b0, 6'h00, 6'h20, 1'b1, 1'b0);
    exp = '0;
    check_output("reset1", S_FETCH);

    // add: 0,1,6,7
    fetch_decode("add", 6'h00, 6'h20);
    apply_stimulus(1'b1, 6'h00, 6'h20, 1'b1, 1'b0);
    exp = '0; exp.alu_src_a = 2'b01; exp.alu_op = 2'b10;
    check_output("add.exec", S_EXEC_R);
    apply_stimulus(1'b1, 6'h00, 6'h20, 1'b1, 1'b0);
    exp = '0; exp.reg_write = 1'b1; exp.reg_dst = 2'b01; exp.instr_done = 1'b1;
    check_output("add.wb", S_RWB);

    // sll: shamt on ALU operand A
    fetch_decode("sll", 6'h00, 6'h00);
    apply_stimulus(1'b1, 6'h00, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.alu_src_a = 2'b10; exp.alu_op = 2'b10;
    check_output("sll.exec", S_EXEC_R);
    apply_stimulus(1'b1, 6'h00, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.reg_write = 1'b1; exp.reg_dst = 2'b01; exp.instr_done = 1'b1;
    check_output("sll.wb", S_RWB);

    // lw with one FETCH stall and three MEMRD stalls
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    exp = fetch_exp(1'b0);
    check_output("lw.fetch_wait", S_FETCH);
    fetch_decode("lw", 6'h23, 6'h00);
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.alu_src_a = 2'b01; exp.alu_src_b = 2'b10; exp.ext_op = 1'b1;
    check_output("lw.memadr", S_MEMADR);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 6'h23, 6'h00, (i == 3), 1'b0);
      exp = '0; exp.mem_read = 1'b1; exp.iord = 1'b1;
      check_output($sformatf("lw.memrd%0d", i), S_MEMRD);
    end
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.reg_write = 1'b1; exp.mem_to_reg = 2'b01; exp.instr_done = 1'b1;
    check_output("lw.memwb", S_MEMWB);

    // sw with one MEMWR stall
    fetch_decode("sw", 6'h2b, 6'h00);
    apply_stimulus(1'b1, 6'h2b, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.alu_src_a = 2'b01; exp.alu_src_b = 2'b10; exp.ext_op = 1'b1;
    check_output("sw.memadr", S_MEMADR);
    apply_stimulus(1'b1, 6'h2b, 6'h00, 1'b0, 1'b0);
    exp = '0; exp.mem_write = 1'b1; exp.iord = 1'b1;
    check_output("sw.memwr_wait", S_MEMWR);
    apply_stimulus(1'b1, 6'h2b, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.mem_write = 1'b1; exp.iord = 1'b1; exp.instr_done = 1'b1;
    check_output("sw.memwr_done", S_MEMWR);

    // beq taken, then not taken
    for (int z = 1; z >= 0; z--) begin
      fetch_decode("beq", 6'h04, 6'h00);
      apply_stimulus(1'b1, 6'h04, 6'h00, 1'b1, z[0]);
      exp = '0; exp.alu_src_a = 2'b01; exp.alu_op = 2'b01; exp.pc_write_cond = 1'b1;
      exp.pc_source = 2'b01; exp.instr_done = 1'b1;
      check_output($sformatf("beq.z%0d", z), S_BRANCH);
      check_bit($sformatf("beq.z%0d.pc_load", z), pc_load, z[0]);
    end

    // andi: zero-extended immediate
    fetch_decode("andi", 6'h0c, 6'h00);
    apply_stimulus(1'b1, 6'h0c, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.alu_src_a = 2'b01; exp.alu_src_b = 2'b10; exp.alu_op = 2'b10;
    check_output("andi.exec", S_EXEC_I);
    apply_stimulus(1'b1, 6'h0c, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.reg_write = 1'b1; exp.instr_done = 1'b1;
    check_output("andi.wb", S_IWB);

    // lui
    fetch_decode("lui", 6'h0f, 6'h00);
    apply_stimulus(1'b1, 6'h0f, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.alu_src_a = 2'b01; exp.alu_src_b = 2'b10; exp.alu_op = 2'b10;
    exp.ext_op = 1'b1; exp.lu_op = 1'b1;
    check_output("lui.exec", S_EXEC_I);
    apply_stimulus(1'b1, 6'h0f, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.reg_write = 1'b1; exp.instr_done = 1'b1;
    check_output("lui.wb", S_IWB);

    // jal links $31 with the PC
    fetch_decode("jal", 6'h03, 6'h00);
    apply_stimulus(1'b1, 6'h03, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.pc_write = 1'b1; exp.pc_source = 2'b10; exp.instr_done = 1'b1;
    exp.reg_write = 1'b1; exp.reg_dst = 2'b10; exp.mem_to_reg = 2'b10;
    check_output("jal.jump", S_JUMP);

    // j does not link
    fetch_decode("j", 6'h02, 6'h00);
    apply_stimulus(1'b1, 6'h02, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.pc_write = 1'b1; exp.pc_source = 2'b10; exp.instr_done = 1'b1;
    check_output("j.jump", S_JUMP);

    // jr
    fetch_decode("jr", 6'h00, 6'h08);
    apply_stimulus(1'b1, 6'h00, 6'h08, 1'b1, 1'b0);
    exp = '0; exp.pc_write = 1'b1; exp.pc_source = 2'b11; exp.instr_done = 1'b1;
    check_output("jr.jr", S_JR);

    // Illegal opcode 3f
    apply_stimulus(1'b1, 6'h3f, 6'h00, 1'b1, 1'b0);
    exp = fetch_exp(1'b1);
    check_output("ill.fetch", S_FETCH);
    apply_stimulus(1'b1, 6'h3f, 6'h00, 1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    exp = decode_exp(1'b0);
    check_output("ill.decode", S_DECODE);
    apply_stimulus(1'b1, 6'h3f, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.trap = 1'b1; exp.pc_write = 1'b1; exp.instr_done = 1'b1;
    check_output("ill.trap", S_TRAP);
`else
    exp = decode_exp(1'b1);
    check_output("ill.decode_nop", S_DECODE);
`endif
    apply_stimulus(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
    exp = fetch_exp(1'b0);
    check_output("ill.back_to_fetch", S_FETCH);

    // Illegal R-type funct 01 behaves the same way in DECODE
    apply_stimulus(1'b1, 6'h00, 6'h01, 1'b1, 1'b0);
    exp = fetch_exp(1'b1);
    check_output("illfn.fetch", S_FETCH);
    apply_stimulus(1'b1, 6'h00, 6'h01, 1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    exp = decode_exp(1'b0);
    check_output("illfn.decode", S_DECODE);
    apply_stimulus(1'b1, 6'h00, 6'h01, 1'b1, 1'b0);
    exp = '0; exp.trap = 1'b1; exp.pc_write = 1'b1; exp.instr_done = 1'b1;
    check_output("illfn.trap", S_TRAP);
`else
    exp = decode_exp(1'b1);
    check_output("illfn.decode_nop", S_DECODE);
`endif

    // Reset in the middle of a lw memory read
    fetch_decode("rstlw", 6'h23, 6'h00);
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b1, 1'b0);
    exp = '0; exp.alu_src_a = 2'b01; exp.alu_src_b = 2'b10; exp.ext_op = 1'b1;
    check_output("rstlw.memadr", S_MEMADR);
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    exp = '0; exp.mem_read = 1'b1; exp.iord = 1'b1;
    check_output("rstlw.memrd", S_MEMRD);
    apply_stimulus(1'b0, 6'h23, 6'h00, 1'b1, 1'b0);
    exp = '0;
    check_output("rstlw.rst_in_memrd", S_MEMRD);
    apply_stimulus(1'b0, 6'h23, 6'h00, 1'b1, 1'b0);
    exp = '0;
    check_output("rstlw.rst_held", S_FETCH);
    apply_stimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    exp = fetch_exp(1'b0);
    check_output("rstlw.first_fetch", S_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
